lsu_align_unit: RTL and testbench

Parametrised load/store alignment unit for the memory stage. It takes one load or store request per handshake and splits any access that crosses a bus word into two aligned beats. Stores use byte strobes instead of read-modify-write; load beats are merged and sign- or zero-extended. It supports 32- and 64-bit data buses and returns a per-access error cause.

---
 rtl/lsu_align_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_lsu_align_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: splits bus-word-crossing accesses into two aligned beats.
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with cause 2.
`timescale 1ns/1ps
module lsu_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              busy_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [4:0]        rsp_rd_o,
  output logic [1:0]        rsp_cause_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W/8-1:0] bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1, ST_RESP} state_t;
  state_t state_reg;

  logic              we_reg, unsigned_reg, cross_reg, flush_pend_reg;
  logic [1:0]        size_reg;
  logic [OFF_W-1:0]  off_reg;
  logic [ADDR_W-1:0] addr1_reg;
  logic [NB-1:0]     be1_reg;
  logic [DATA_W-1:0] wdata1_reg, rdata0_reg;

  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic [4:0]        rsp_rd_reg;
  logic [1:0]        rsp_cause_reg;
  logic              bus_req_reg, bus_we_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [NB-1:0]     bus_be_reg;
  logic [DATA_W-1:0] bus_wdata_reg;

  logic [OFF_W-1:0]    req_off;
  logic [2*NB-1:0]     req_mask, req_be_wide;
  logic [2*DATA_W-1:0] req_wd_wide;
  logic [ADDR_W-1:0]   req_addr0;
  logic                req_cross, req_illegal, accept;

  // Shifting into a double-width vector yields both beats at once:
  // the low half is beat 0, the high half is beat 1.
  always_comb begin
    req_off  = req_addr_i[OFF_W-1:0];
    req_mask = '0;
    case (req_size_i)
      2'd0:    req_mask[0:0] = '1;
      2'd1:    req_mask[1:0] = '1;
      2'd2:    req_mask[3:0] = '1;
      default: req_mask[7:0] = '1;
    endcase
    req_be_wide = req_mask << req_off;
    req_wd_wide = {{DATA_W{1'b0}}, req_wdata_i} << {req_off, 3'b000};
    req_cross   = (int'(req_off) + (1 << req_size_i)) > NB;
    req_illegal = (req_size_i == 2'd3) && (DATA_W == 32);
    req_addr0   = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_misalign;
  assign req_misalign = |(req_off & OFF_W'((1 << req_size_i) - 1));
`endif

  assign req_ready_o = (state_reg == ST_IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign busy_o      = (state_reg != ST_IDLE);
  assign rsp_valid_o = rsp_valid_reg && !flush_i;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_rd_o    = rsp_rd_reg;
  assign rsp_cause_o = rsp_cause_reg;
  assign bus_req_o   = bus_req_reg;
  assign bus_we_o    = bus_we_reg;
  assign bus_addr_o  = bus_addr_reg;
  assign bus_be_o    = bus_be_reg;
  assign bus_wdata_o = bus_wdata_reg;

  function automatic logic [DATA_W-1:0] load_result(
    input logic [DATA_W-1:0] lo,
    input logic [DATA_W-1:0] hi,
    input logic [OFF_W-1:0]  off,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [DATA_W-1:0] raw, res;
    logic              sign;
    int                nbits;
    raw   = DATA_W'({hi, lo} >> {off, 3'b000});
    nbits = 8 << size;
    case (size)
      2'd0:    sign = raw[7];
      2'd1:    sign = raw[15];
      2'd2:    sign = raw[31];
      default: sign = raw[DATA_W-1];
    endcase
    for (int i = 0; i < DATA_W; i++)
      res[i] = (i < nbits) ? raw[i] : (sign & ~uns);
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      we_reg         <= 1'b0;
      unsigned_reg   <= 1'b0;
      cross_reg      <= 1'b0;
      flush_pend_reg <= 1'b0;
      size_reg       <= '0;
      off_reg        <= '0;
      addr1_reg      <= '0;
      be1_reg        <= '0;
      wdata1_reg     <= '0;
      rdata0_reg     <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_rdata_reg  <= '0;
      rsp_rd_reg     <= '0;
      rsp_cause_reg  <= '0;
      bus_req_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_addr_reg   <= '0;
      bus_be_reg     <= '0;
      bus_wdata_reg  <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            we_reg         <= req_we_i;
            size_reg       <= req_size_i;
            unsigned_reg   <= req_unsigned_i;
            off_reg        <= req_off;
            cross_reg      <= req_cross;
            addr1_reg      <= req_addr0 + ADDR_W'(NB);
            be1_reg        <= req_be_wide[2*NB-1:NB];
            wdata1_reg     <= req_wd_wide[2*DATA_W-1:DATA_W];
            rsp_rd_reg     <= req_rd_i;
            rsp_rdata_reg  <= '0;
            rsp_cause_reg  <= 2'd0;
            flush_pend_reg <= 1'b0;
            if (req_illegal) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_cause_reg <= 2'd3;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            else if (req_misalign) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_cause_reg <= 2'd2;
            end
`endif
            else begin
              state_reg     <= ST_BEAT0;
              bus_req_reg   <= 1'b1;
              bus_we_reg    <= req_we_i;
              bus_addr_reg  <= req_addr0;
              bus_be_reg    <= req_be_wide[NB-1:0];
              bus_wdata_reg <= req_wd_wide[DATA_W-1:0];
            end
          end
        end
        ST_BEAT0: begin
          // A flush during a live beat is remembered and honoured at the ack.
          if (flush_i) flush_pend_reg <= 1'b1;
          if (bus_ack_i) begin
            bus_req_reg <= 1'b0;
            rdata0_reg  <= bus_rdata_i;
            if (flush_i || flush_pend_reg) begin
              state_reg <= ST_IDLE;
            end else if (bus_err_i) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_cause_reg <= 2'd1;
            end else if (cross_reg) begin
              state_reg <= ST_BEAT1;
            end else begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_rdata_reg <= we_reg ? '0 :
                load_result(bus_rdata_i, '0, off_reg, size_reg, unsigned_reg);
            end
          end
        end
        ST_BEAT1: begin
          if (!bus_req_reg) begin
            // Idle gap cycle between beats.
            if (flush_i) begin
              state_reg <= ST_IDLE;
            end else begin
              bus_req_reg   <= 1'b1;
              bus_addr_reg  <= addr1_reg;
              bus_be_reg    <= be1_reg;
              bus_wdata_reg <= wdata1_reg;
            end
          end else begin
            if (flush_i) flush_pend_reg <= 1'b1;
            if (bus_ack_i) begin
              bus_req_reg <= 1'b0;
              if (flush_i || flush_pend_reg) begin
                state_reg <= ST_IDLE;
              end else begin
                state_reg     <= ST_RESP;
                rsp_valid_reg <= 1'b1;
                if (bus_err_i)
                  rsp_cause_reg <= 2'd1;
                else
                  rsp_rdata_reg <= we_reg ? '0 :
                    load_result(rdata0_reg, bus_rdata_i, off_reg, size_reg, unsigned_reg);
              end
            end
          end
        end
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit: 32-bit instance with a small bus model plus a 64-bit instance.
`timescale 1ns/1ps
module tb_lsu_align_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- 32-bit instance ----------------
  logic        flush = 1'b0, req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready, busy, rsp_valid, bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] rsp_rdata, bus_addr, bus_wdata, mem_rdata;
  logic [4:0]  rsp_rd;
  logic [1:0]  rsp_cause;
  logic [3:0]  bus_be;
  logic        ack_en = 1'b1, err_en = 1'b0;

  lsu_align_unit #(.DATA_W(32), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd), .busy_o(busy),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_rd_o(rsp_rd), .rsp_cause_o(rsp_cause),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_rdata_i(mem_rdata)
  );

  always_comb begin
    case (bus_addr)
      32'h0000_1000: mem_rdata = 32'hDDCC_BBAA;
      32'h0000_1004: mem_rdata = 32'h4433_2211;
      32'hFFFF_FFFC: mem_rdata = 32'h8765_4321;
      32'h0000_0000: mem_rdata = 32'h0FED_CBA9;
      default:       mem_rdata = 32'h0;
    endcase
  end
  assign bus_ack = bus_req & ack_en;
  assign bus_err = bus_req & err_en;

  logic [31:0] b_addr [0:63];
  logic [31:0] b_wd   [0:63];
  logic [3:0]  b_be   [0:63];
  logic        b_we   [0:63];
  int          b_cnt = 0, r_cnt = 0, r_cyc = 0;
  logic [31:0] r_rdata = '0;
  logic [1:0]  r_cause = '0;
  logic [4:0]  r_rd = '0;

  always @(negedge clk) begin
    if (bus_req && bus_ack) begin
      b_addr[b_cnt % 64] = bus_addr;
      b_wd[b_cnt % 64]   = bus_wdata;
      b_be[b_cnt % 64]   = bus_be;
      b_we[b_cnt % 64]   = bus_we;
      b_cnt++;
    end
    if (rsp_valid) begin
      r_rdata = rsp_rdata;
      r_cause = rsp_cause;
      r_rd    = rsp_rd;
      r_cyc   = cyc;
      r_cnt++;
    end
  end

  int acc_cyc = 0, b_base = 0, r_base = 0;

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    tick();
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    acc_cyc = cyc; b_base = b_cnt; r_base = r_cnt;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (r_cnt == r_base && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_seen", 64'(r_cnt - r_base), 64'd1);
  endtask

  task automatic run_txn(input string name, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] exp_data, input logic [1:0] exp_cause,
                         input int exp_lat, input int exp_beats);
    issue(we, size, uns, addr, wdata, rd);
    wait_rsp();
    chk({name, ".rdata"}, r_rdata, exp_data);
    chk({name, ".cause"}, r_cause, exp_cause);
    chk({name, ".rd"}, r_rd, rd);
    chk({name, ".latency"}, 64'(r_cyc - acc_cyc), 64'(exp_lat));
    chk({name, ".beats"}, 64'(b_cnt - b_base), 64'(exp_beats));
    $display("txn %s addr=0x%08h rdata=0x%08h cause=%0d beats=%0d latency=%0d",
             name, addr, r_rdata, r_cause, b_cnt - b_base, r_cyc - acc_cyc);
  endtask

  // ---------------- 64-bit instance ----------------
  logic        d_valid = 1'b0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0;
  logic        d_ready, d_busy, d_rsp_valid, d_bus_req, d_bus_we;
  logic [63:0] d_rsp_rdata, d_bus_wdata, d_mem_rdata;
  logic [4:0]  d_rsp_rd;
  logic [1:0]  d_rsp_cause;
  logic [31:0] d_bus_addr;
  logic [7:0]  d_bus_be;

  lsu_align_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .flush_i(1'b0),
    .req_valid_i(d_valid), .req_ready_o(d_ready), .req_we_i(1'b0),
    .req_size_i(d_size), .req_unsigned_i(1'b0), .req_addr_i(d_addr),
    .req_wdata_i(64'h0), .req_rd_i(5'd3), .busy_o(d_busy),
    .rsp_valid_o(d_rsp_valid), .rsp_rdata_o(d_rsp_rdata), .rsp_rd_o(d_rsp_rd),
    .rsp_cause_o(d_rsp_cause),
    .bus_req_o(d_bus_req), .bus_we_o(d_bus_we), .bus_addr_o(d_bus_addr), .bus_be_o(d_bus_be),
    .bus_wdata_o(d_bus_wdata), .bus_ack_i(d_bus_req), .bus_err_i(1'b0), .bus_rdata_i(d_mem_rdata)
  );

  always_comb begin
    case (d_bus_addr)
      32'h0000_2000: d_mem_rdata = 64'h8877_6655_4433_2211;
      32'h0000_2008: d_mem_rdata = 64'h00FF_EEDD_CCBB_AA99;
      default:       d_mem_rdata = 64'h0;
    endcase
  end

  logic [31:0] d_b_addr [0:7];
  logic [7:0]  d_b_be   [0:7];
  int          d_b_cnt = 0, d_r_cnt = 0;
  logic [63:0] d_r_rdata = '0;
  logic [1:0]  d_r_cause = '0;

  always @(negedge clk) begin
    if (d_bus_req) begin
      d_b_addr[d_b_cnt % 8] = d_bus_addr;
      d_b_be[d_b_cnt % 8]   = d_bus_be;
      d_b_cnt++;
    end
    if (d_rsp_valid) begin
      d_r_rdata = d_rsp_rdata;
      d_r_cause = d_rsp_cause;
      d_r_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset.req_ready", req_ready, 1'b1);
    chk("reset.busy", busy, 1'b0);
    chk("reset.bus_req", bus_req, 1'b0);
    chk("reset.rsp_valid", rsp_valid, 1'b0);
    chk("reset.bus_be", bus_be, 4'h0);
    tick();

    run_txn("lw_cross", 1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 5'd5, 32'h2211DDCC, 2'd0, 4, 2);
    chk("lw_cross.b0_addr", b_addr[b_base], 32'h1000);
    chk("lw_cross.b0_be", b_be[b_base], 4'b1100);
    chk("lw_cross.b1_addr", b_addr[b_base+1], 32'h1004);
    chk("lw_cross.b1_be", b_be[b_base+1], 4'b0011);

    run_txn("sh_cross", 1'b1, 2'd1, 1'b0, 32'h1003, 32'h0000BEEF, 5'd6, 32'h0, 2'd0, 4, 2);
    chk("sh_cross.b0_addr", b_addr[b_base], 32'h1000);
    chk("sh_cross.b0_be", b_be[b_base], 4'b1000);
    chk("sh_cross.b0_wdata", b_wd[b_base], 32'hEF000000);
    chk("sh_cross.b0_we", b_we[b_base], 1'b1);
    chk("sh_cross.b1_addr", b_addr[b_base+1], 32'h1004);
    chk("sh_cross.b1_be", b_be[b_base+1], 4'b0001);
    chk("sh_cross.b1_wdata", b_wd[b_base+1], 32'h000000BE);

    run_txn("lb", 1'b0, 2'd0, 1'b0, 32'h1001, 32'h0, 5'd7, 32'hFFFFFFBB, 2'd0, 2, 1);
    chk("lb.b0_be", b_be[b_base], 4'b0010);
    run_txn("lbu", 1'b0, 2'd0, 1'b1, 32'h1001, 32'h0, 5'd8, 32'h000000BB, 2'd0, 2, 1);

    run_txn("lw_wrap", 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 5'd10, 32'hCBA98765, 2'd0, 4, 2);
    chk("lw_wrap.b0_addr", b_addr[b_base], 32'hFFFFFFFC);
    chk("lw_wrap.b1_addr", b_addr[b_base+1], 32'h00000000);

    err_en = 1'b1;
    run_txn("lw_err", 1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 5'd11, 32'h0, 2'd1, 2, 1);
    err_en = 1'b0;

    run_txn("ld_illegal", 1'b0, 2'd3, 1'b0, 32'h1000, 32'h0, 5'd12, 32'h0, 2'd3, 1, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    run_txn("lh_misalign", 1'b0, 2'd1, 1'b0, 32'h1001, 32'h0, 5'd13, 32'h0, 2'd2, 1, 0);
`else
    run_txn("lh_misalign", 1'b0, 2'd1, 1'b0, 32'h1001, 32'h0, 5'd13, 32'hFFFFCCBB, 2'd0, 2, 1);
`endif

    // Flush while beat 1 is held waiting for ack.
    ack_en = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 5'd14);
    tick();
    ack_en = 1'b0;
    tick();
    chk("flush.beat1_held", bus_req, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush.beat1_still_held", bus_req, 1'b1);
    ack_en = 1'b1;
    tick();
    chk("flush.req_ready", req_ready, 1'b1);
    chk("flush.busy", busy, 1'b0);
    chk("flush.bus_req", bus_req, 1'b0);
    repeat (4) tick();
    chk("flush.no_rsp", 64'(r_cnt - r_base), 64'd0);
    chk("flush.beats", 64'(b_cnt - b_base), 64'd2);
    $display("txn flush_lw addr=0x00001002 beats=%0d responses=%0d", b_cnt - b_base, r_cnt - r_base);

    run_txn("lw_after_flush", 1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 5'd15, 32'h44332211, 2'd0, 2, 1);

    // 64-bit bus: crossing dword load.
    begin
      int bb, rb, n;
      tick();
      d_valid = 1'b1; d_size = 2'd3; d_addr = 32'h2005;
      bb = d_b_cnt; rb = d_r_cnt;
      tick();
      d_valid = 1'b0;
      n = 0;
      while (d_r_cnt == rb && n < 20) begin
        tick();
        n++;
      end
      chk("ld64.rsp_seen", 64'(d_r_cnt - rb), 64'd1);
      chk("ld64.beats", 64'(d_b_cnt - bb), 64'd2);
      chk("ld64.b0_addr", d_b_addr[bb % 8], 32'h2000);
      chk("ld64.b0_be", d_b_be[bb % 8], 8'hE0);
      chk("ld64.b1_addr", d_b_addr[(bb+1) % 8], 32'h2008);
      chk("ld64.b1_be", d_b_be[(bb+1) % 8], 8'h1F);
      chk("ld64.rdata", d_r_rdata, 64'hDDCCBBAA99887766);
      chk("ld64.cause", d_r_cause, 2'd0);
      $display("txn ld64 addr=0x00002005 rdata=0x%016h beats=%0d", d_r_rdata, d_b_cnt - bb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
